i2s_transmisor: RTL and testbench

// - Audio-output counterpart to the microphone capture path: takes parallel stereo PCM samples, serializes them to a DAC in I2S.
// - Generates bit clock (sclk) and word select (ws) from system clock; MSB first, one-sclk I2S delay after ws change.
// - Sits between the audio sample source and the board audio codec pins.

---
 rtl/audio_pkg.sv | 18 +
 rtl/i2s_sclk_gen.sv | 36 +++
 rtl/i2s_transmisor.sv | 108 ++++++++++
 tb/tb_i2s_transmisor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio defaults and width helpers for the I2S transmit path
package audio_pkg;

  localparam int AUDIO_DATA_W  = 16;
  localparam int AUDIO_CLK_DIV = 4;
  localparam int SLOTS         = 2 * AUDIO_DATA_W;
  localparam int SLOT_W        = $clog2(SLOTS);

  function automatic int slot_w(input int data_w);
    return $clog2(2 * data_w);
  endfunction

  // A divide-by-one still needs a one-bit counter register.
  function automatic int cnt_w(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// rtl/i2s_sclk_gen.sv - bit-clock divider producing sclk and a falling-edge strobe
module i2s_sclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = AUDIO_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_sclk,
  output logic o_fall_stb
);

  localparam int CNT_W = cnt_w(CLK_DIV);

  logic [CNT_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_term;

  assign w_term     = (r_div_cnt == CNT_W'(CLK_DIV - 1));
  // Strobe coincides with the clk edge on which sclk drops to 0.
  assign o_fall_stb = w_term & r_sclk;
  assign o_sclk     = r_sclk;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (w_term) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2s_transmisor.sv
// rtl/i2s_transmisor.sv - I2S stereo transmitter; UNDERRUN_HOLD_EN repeats the last pair on underrun
module i2s_transmisor
  import audio_pkg::*;
#(
  parameter int DATA_W  = AUDIO_DATA_W,
  parameter int CLK_DIV = AUDIO_CLK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sclk,
  output logic              ws,
  output logic              sdata,
  output logic              underrun
);

  localparam int SW = slot_w(DATA_W);
  localparam int FW = 2 * DATA_W;
  localparam logic [SW-1:0] SLOT_LAST = SW'(FW - 1);
  localparam logic [SW-1:0] SLOT_WS_R = SW'(DATA_W - 1);

  logic          w_fall_stb;
  logic [SW-1:0] w_slot_next;
  logic          w_load;
  logic          w_accept;
  logic [FW-1:0] w_frame;

  logic [SW-1:0] r_slot;
  logic          r_full;
  logic [FW-1:0] r_hold;
  logic [FW-1:0] r_shift;
  logic          r_ws;
  logic          r_sdata;
  logic          r_underrun;
`ifdef UNDERRUN_HOLD_EN
  logic [FW-1:0] r_last;
`endif

  i2s_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .i_clk     (clk),
    .i_reset   (reset),
    .o_sclk    (sclk),
    .o_fall_stb(w_fall_stb)
  );

  assign w_slot_next = (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);
  assign w_load      = w_fall_stb && (w_slot_next == '0);
  assign w_accept    = s_valid && !r_full;

`ifdef UNDERRUN_HOLD_EN
  assign w_frame = r_full ? r_hold : r_last;
`else
  assign w_frame = r_full ? r_hold : '0;
`endif

  assign s_ready  = ~r_full;
  assign ws       = r_ws;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot     <= SLOT_LAST;
      r_full     <= 1'b0;
      r_hold     <= '0;
      r_shift    <= '0;
      r_ws       <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
`ifdef UNDERRUN_HOLD_EN
      r_last     <= '0;
`endif
    end else begin
      r_underrun <= 1'b0;
      if (w_fall_stb) begin
        r_slot <= w_slot_next;
        // ws leads each channel's MSB by one slot.
        if (w_slot_next == SLOT_WS_R)
          r_ws <= 1'b1;
        else if (w_slot_next == SLOT_LAST)
          r_ws <= 1'b0;
        if (w_load) begin
          r_shift    <= w_frame;
          r_sdata    <= w_frame[FW-1];
          r_underrun <= ~r_full;
          r_full     <= 1'b0;
`ifdef UNDERRUN_HOLD_EN
          r_last     <= w_frame;
`endif
        end else begin
          r_shift <= {r_shift[FW-2:0], 1'b0};
          r_sdata <= r_shift[FW-2];
        end
      end
      // Accept after load: a pair arriving on the load clk waits for the next frame.
      if (w_accept) begin
        r_full <= 1'b1;
        r_hold <= {s_left, s_right};
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmisor.sv
// tb/tb_i2s_transmisor.sv - directed scoreboard bench for i2s_transmisor
module tb_i2s_transmisor;

  localparam int DW     = 16;
  localparam int CD     = 4;
  localparam int FW     = 2 * DW;
  localparam int PERIOD = 4 * DW * CD;
  localparam int FIRST  = 2 * CD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          s_ready;
  logic          sclk;
  logic          ws;
  logic          sdata;
  logic          underrun;

  i2s_transmisor #(
    .DATA_W (DW),
    .CLK_DIV(CD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_left  (s_left),
    .s_right (s_right),
    .sclk    (sclk),
    .ws      (ws),
    .sdata   (sdata),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: clocks since reset release, holding register, expected frames.
  int          m_cnt = 0;
  bit          m_started = 0;
  bit          m_full = 0;
  bit          m_full_b = 0;
  bit          m_acc = 0;
  bit          m_load = 0;
  bit          m_exp_ur = 0;
  logic [31:0] m_hold = '0;
  logic [31:0] m_last = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    m_started = 1;
    m_acc     = 0;
    m_load    = 0;
    m_exp_ur  = 0;
    if (reset) begin
      m_cnt  = 0;
      m_full = 0;
      m_hold = '0;
      m_last = '0;
      exp_q.delete();
    end else begin
      m_full_b = m_full;
      m_cnt++;
      if (m_cnt >= FIRST && (m_cnt - FIRST) % PERIOD == 0) begin
        m_load = 1;
        if (m_full) begin
          exp_q.push_back(m_hold);
          m_last = m_hold;
          m_full = 0;
        end else begin
          m_exp_ur = 1;
`ifdef UNDERRUN_HOLD_EN
          exp_q.push_back(m_last);
`else
          exp_q.push_back(32'h0);
`endif
        end
      end
      if (s_valid && !m_full_b) begin
        m_acc  = 1;
        m_full = 1;
        m_hold = {s_left, s_right};
      end
    end
  end

  // Monitor: samples sdata/ws on each sclk rise, assembles frames, pops scoreboard.
  bit          mon_active = 0;
  bit          prev_sclk = 0;
  int          mon_bit = 0;
  int          mon_frames = 0;
  logic [31:0] mon_word = '0;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    if (m_started) begin
      chk("s_ready", {31'b0, s_ready}, {31'b0, !m_full});
      chk("underrun", {31'b0, underrun}, {31'b0, m_exp_ur});
    end
    if (reset) begin
      mon_active = 0;
      prev_sclk  = 0;
    end else begin
      if (m_load) begin
        mon_active = 1;
        mon_bit    = 0;
        mon_word   = '0;
      end
      if (!prev_sclk && sclk && mon_active) begin
        chk("ws", {31'b0, ws}, {31'b0, (mon_bit >= DW - 1 && mon_bit <= FW - 2)});
        mon_word = {mon_word[30:0], sdata};
        if (mon_bit == FW - 1) begin
          mon_frames++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL frame_unexpected observed=%h expected=none", mon_word);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("frame", mon_word, mon_exp);
          end
          mon_active = 0;
        end
        mon_bit++;
      end
      prev_sclk = sclk;
    end
  end

  task automatic wait_cnt(input int n);
    for (int k = 0; k < 2000 && m_cnt != n; k++) @(negedge clk);
    if (m_cnt != n) begin
      n_checks++;
      n_errors++;
      $error("FAIL wait_cnt observed=%0d expected=%0d", m_cnt, n);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int k = 0; k < 4000 && mon_frames < n; k++) @(negedge clk);
    if (mon_frames < n) begin
      n_checks++;
      n_errors++;
      $error("FAIL wait_frames observed=%0d expected=%0d", mon_frames, n);
    end
  endtask

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit done;
    done    = 0;
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      done = m_acc;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_pair observed=not_accepted expected=accepted");
    end
    s_valid = 1'b0;
    s_left  = DW'($urandom);
    s_right = DW'($urandom);
  endtask

  task automatic startup_timing();
    send_pair(16'hA5F0, 16'h0F0F);
    wait_cnt(4);
    chk("sclk_first_rise", {31'b0, sclk}, 32'd1);
    wait_cnt(7);
    chk("sclk_before_fall", {31'b0, sclk}, 32'd1);
    wait_cnt(8);
    chk("sclk_first_fall", {31'b0, sclk}, 32'd0);
    chk("ws_first_fall", {31'b0, ws}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  f0;
    bit  hit;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", {31'b0, sclk}, 32'd0);
    chk("rst_ws", {31'b0, ws}, 32'd0);
    chk("rst_sdata", {31'b0, sdata}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);

    reset = 1'b0;
    startup_timing();

    send_pair(16'h1234, 16'h5678);
    send_pair(16'h8765, 16'h4321);
    send_pair(16'hFFFF, 16'h0000);
    send_pair(16'h8000, 16'h0001);
    wait_frames(6);

    // Present a pair exactly on a load clk while holding is empty.
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      if (!m_full && m_cnt >= FIRST - 1 && (m_cnt + 1 - FIRST) % PERIOD == 0)
        hit = 1;
      else
        @(negedge clk);
    end
    f0      = mon_frames;
    s_valid = 1'b1;
    s_left  = 16'h7FFF;
    s_right = 16'h8001;
    @(negedge clk);
    chk("load_clk_underrun", {31'b0, underrun}, 32'd1);
    chk("load_clk_s_ready", {31'b0, s_ready}, 32'd0);
    s_valid = 1'b0;
    wait_frames(f0 + 2);

    // Reset in the middle of a frame at slot 20, with holding full.
    send_pair(16'h1357, 16'h2468);
    send_pair(16'h1111, 16'h2222);
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      if (m_cnt > FIRST && (m_cnt - FIRST) % PERIOD == 20 * 2 * CD + 2)
        hit = 1;
      else
        @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_sclk", {31'b0, sclk}, 32'd0);
    chk("midrst_ws", {31'b0, ws}, 32'd0);
    chk("midrst_sdata", {31'b0, sdata}, 32'd0);
    chk("midrst_s_ready", {31'b0, s_ready}, 32'd1);
    chk("midrst_underrun", {31'b0, underrun}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    f0    = mon_frames;
    startup_timing();
    wait_frames(f0 + 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
